pc_select_unit: RTL and testbench
=================================

# pc_select_unit

Parametrised successor to the 16-bit next-PC muxing and jump-address logic. It owns the fetch PC register and selects the next PC from four sources: sequential, branch, jump and register. It supports stall hold, issues a redirect pulse to the pipeline flush logic, and includes an optional return-address stack (RAS). It sits at the IF stage, is fed by ID/EX control, and drives the I-cache fetch address.

## Interface
Parameters:
- `WIDTH`, 16: PC and address width.
- `JUMP_FIELD`, 12: immediate bits of a jump target; must be < `WIDTH`.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, ≥2.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hold PC and RAS; ignore `sel`, `is_call` and `is_return`.
- `sel` in 2: next-PC source. 00 = seq, 01 = branch, 10 = jump, 11 = register.
- `base_pc` in `WIDTH`: PC of the instruction resolving the jump or call (ID-stage PC).
- `jump_imm` in `JUMP_FIELD`: jump immediate field.
- `branch_target` in `WIDTH`: computed branch target.
- `reg_target` in `WIDTH`: register-indirect target (JR/JRL).
- `is_call` in 1: link instruction; push `base_pc`+1 on accepted update.
- `is_return` in 1: return instruction (only meaningful with `sel`=11).
- `pc` out `WIDTH`: registered fetch PC.
- `pc_plus1` out `WIDTH`: combinational `pc`+1.
- `redirect` out 1: registered; 1 for the cycle after a non-sequential update.
- `ras_empty` out 1, `ras_full` out 1: RAS status.
- `ras_underflow` out 1: registered one-cycle pulse on a return with an empty RAS.

## Operation
- Next-PC computation:
  - seq: `pc`+1, modulo 2^`WIDTH`.
  - branch: `branch_target`.
  - jump: {`base_pc`[`WIDTH`-1:`JUMP_FIELD`], `jump_imm`}.
  - register: `reg_target`; with RAS enabled and `is_return`=1 and RAS non-empty, the RAS top instead.
- Update rule: if `stall`=0, then `pc` ← next PC and `redirect` ← (`sel`≠00). If `stall`=1, `pc` holds and `redirect` ← 0.
- RAS is a circular buffer with a pointer and an occupancy count (0..`RAS_DEPTH`). All RAS operations require `stall`=0.
  - Push (`is_call`): write `base_pc`+1 at the top; count saturates at `RAS_DEPTH`.
  - Push when full: overwrites the oldest entry; `ras_full` stays 1 and no error is flagged.
  - Pop (`is_return` with `sel`=11): read the top, decrement the count.
  - Pop when empty: use `reg_target`, leave the count at 0, and pulse `ras_underflow`.
  - `is_call` and `is_return` together: the pop value selects the PC, then `base_pc`+1 replaces the top. Net count is unchanged; when empty, behaves as a push.
  - `is_call`/`is_return` with any other `sel`: `is_return` is ignored; `is_call` still pushes.
- `ras_empty` = (count==0); `ras_full` = (count==`RAS_DEPTH`).
- Reset: `pc`=`RESET_PC`, `redirect`=0, `ras_underflow`=0, count=0, pointer=0, `ras_empty`=1, `ras_full`=0. RAS entry contents are don't-care.
- Reset asserted mid-operation overrides stall and every push/pop in that cycle.

## Timing
- Next PC is combinational from the inputs. `pc` updates one clock after the inputs are presented (latency 1).
- `redirect` and `ras_underflow` are valid in the same cycle the new `pc` appears, and last one cycle unless the condition repeats.
- A RAS push is visible to a pop in the following cycle; there is no same-cycle bypass except the simultaneous call+return case.
- `pc_plus1` follows `pc` combinationally, with no extra latency.

## Configuration
- `PC_SELECT_RAS_EN` defined: RAS is present as described above.
- `PC_SELECT_RAS_EN` undefined:
  - No RAS storage.
  - `sel`=11 always uses `reg_target`.
  - `is_call` and `is_return` are ignored.
  - `ras_empty`=1, `ras_full`=0 and `ras_underflow`=0 constantly.
- The `RAS_DEPTH` parameter is accepted but unused when the macro is undefined.

## Test plan
- Reset then 3 cycles with `sel`=00, `stall`=0 → `pc` = 0, 1, 2, 3; `redirect`=0 throughout.
- `pc`=0xFFFF, `sel`=00 → `pc`=0x0000 (wrap). Then `sel`=10, `base_pc`=0x5123, `jump_imm`=0xABC → `pc`=0x5ABC and `redirect`=1 for exactly one cycle.
- `stall`=1 with `sel`=01, `branch_target`=0x0040, for 2 cycles → `pc` holds and `redirect`=0. Release stall → `pc`=0x0040 and `redirect`=1.
- RAS (macro on, `RAS_DEPTH`=4):
  - Push `base_pc` = 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_full`=1.
  - Then 4 returns with `sel`=11, `reg_target`=0x7777 → `pc` = 0x51, 0x41, 0x31, 0x21 and `ras_empty`=1.
  - A fifth return → `pc`=0x7777 and `ras_underflow`=1.
- Simultaneous call+return with one entry 0x0101 and `base_pc`=0x0200 → `pc`=0x0101; the next return yields 0x0201; count ends at 0.
- Macro off: `sel`=11, `is_return`=1 after a call, `reg_target`=0x1234 → `pc`=0x1234, `ras_empty`=1; `reset` asserted with `stall`=1 → `pc`=`RESET_PC` on the next edge.

Source files
------------

// File: rtl/pc_select_unit_if.sv
// pc_select_unit_if: control/status bundle between the ID/EX control logic and the
// IF-stage PC selection unit.
//   master : driven by pipeline control (stall, sel, targets, call/return flags);
//            observes pc, pc_plus1, redirect and RAS status.
//   slave  : the pc_select_unit side.
// WIDTH and JUMP_FIELD must match the parameters of the attached pc_select_unit.
interface pc_select_unit_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned JUMP_FIELD = 12
);
  logic                  stall;
  logic [1:0]            sel;
  logic [WIDTH-1:0]      base_pc;
  logic [JUMP_FIELD-1:0] jump_imm;
  logic [WIDTH-1:0]      branch_target;
  logic [WIDTH-1:0]      reg_target;
  logic                  is_call;
  logic                  is_return;
  logic [WIDTH-1:0]      pc;
  logic [WIDTH-1:0]      pc_plus1;
  logic                  redirect;
  logic                  ras_empty;
  logic                  ras_full;
  logic                  ras_underflow;

  modport master (
    output stall, sel, base_pc, jump_imm, branch_target, reg_target, is_call, is_return,
    input  pc, pc_plus1, redirect, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, sel, base_pc, jump_imm, branch_target, reg_target, is_call, is_return,
    output pc, pc_plus1, redirect, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_select_unit.sv
// pc_select_unit: owns the IF-stage fetch PC and selects the next PC from sequential,
// branch, jump and register sources, with stall hold, a registered redirect pulse and an
// optional return-address stack (RAS).
//
// Optional feature macro: PC_SELECT_RAS_EN (defined -> RAS present; undefined -> no RAS,
// sel=11 always takes reg_target, RAS status outputs tied to empty/not-full/no-underflow).
//
// Ports:
//   clk   : clock, all state updates on rising edge
//   reset : synchronous, active-high reset
//   bus   : pc_select_unit_if.slave
//           in  stall, sel, base_pc, jump_imm, branch_target, reg_target, is_call, is_return
//           out pc (registered), pc_plus1 (comb), redirect (registered),
//               ras_empty, ras_full, ras_underflow (registered pulse)
module pc_select_unit #(
  parameter int unsigned     WIDTH      = 16,
  parameter int unsigned     JUMP_FIELD = 12,
  parameter int unsigned     RAS_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input logic              clk,
  input logic              reset,
  pc_select_unit_if.slave  bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] jump_pc;
  logic [WIDTH-1:0] reg_pc;
  logic             redirect_q;

  // Jump keeps the upper bits of the resolving instruction's PC.
  assign jump_pc = {bus.base_pc[WIDTH-1:JUMP_FIELD], bus.jump_imm};

`ifdef PC_SELECT_RAS_EN
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  // ras_ptr_q is the next write slot; the top of stack lives at ras_ptr_q-1.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PtrW-1:0]  ras_ptr_q;
  logic [PtrW-1:0]  top_idx;
  logic [CntW-1:0]  ras_cnt_q;
  logic             ras_underflow_q;
  logic             ras_nonempty;
  logic             ras_is_full;
  logic             push_req;
  logic             pop_req;
  logic [WIDTH-1:0] link_addr;

  assign top_idx      = ras_ptr_q - PtrW'(1);
  assign ras_nonempty = (ras_cnt_q != '0);
  assign ras_is_full  = (ras_cnt_q == CntW'(RAS_DEPTH));
  assign push_req     = !bus.stall && bus.is_call;
  assign pop_req      = !bus.stall && bus.is_return && (bus.sel == 2'b11);
  assign link_addr    = bus.base_pc + WIDTH'(1);
  assign reg_pc       = (bus.is_return && ras_nonempty) ? ras_mem[top_idx] : bus.reg_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr_q       <= '0;
      ras_cnt_q       <= '0;
      ras_underflow_q <= 1'b0;
    end else begin
      // Call+return on an empty stack acts as a plain push, so no underflow there.
      ras_underflow_q <= pop_req && !push_req && !ras_nonempty;
      if (push_req && pop_req && ras_nonempty) begin
        // Top replaced in place: pointer and count unchanged.
      end else if (push_req) begin
        ras_ptr_q <= ras_ptr_q + PtrW'(1);
        if (!ras_is_full) begin
          ras_cnt_q <= ras_cnt_q + CntW'(1);
        end
      end else if (pop_req && ras_nonempty) begin
        ras_ptr_q <= top_idx;
        ras_cnt_q <= ras_cnt_q - CntW'(1);
      end
    end
  end

  // Entry storage needs no reset; a full-stack push lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (!reset && push_req) begin
      if (pop_req && ras_nonempty) begin
        ras_mem[top_idx] <= link_addr;
      end else begin
        ras_mem[ras_ptr_q] <= link_addr;
      end
    end
  end

  assign bus.ras_empty     = !ras_nonempty;
  assign bus.ras_full      = ras_is_full;
  assign bus.ras_underflow = ras_underflow_q;
`else
  logic unused_ras;

  assign unused_ras        = ^{bus.is_call, bus.is_return, bus.base_pc[JUMP_FIELD-1:0]};
  assign reg_pc            = bus.reg_target;
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_full      = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  always_comb begin
    next_pc = pc_q + WIDTH'(1);
    unique case (bus.sel)
      2'b00:   next_pc = pc_q + WIDTH'(1);
      2'b01:   next_pc = bus.branch_target;
      2'b10:   next_pc = jump_pc;
      2'b11:   next_pc = reg_pc;
      default: next_pc = pc_q + WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q       <= next_pc;
      redirect_q <= (bus.sel != 2'b00);
    end else begin
      redirect_q <= 1'b0;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus1 = pc_q + WIDTH'(1);
  assign bus.redirect = redirect_q;

endmodule

// File: tb/tb_pc_select_unit.sv
// Scoreboard bench for pc_select_unit: the driver applies one directed vector per cycle
// and queues the expected state after the next edge; the monitor pops and compares after
// every rising edge. RAS vectors run only when PC_SELECT_RAS_EN is defined; otherwise the
// RAS-disabled behaviour is exercised.
module tb_pc_select_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        redirect;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;
  } obs_t;

  logic clk;
  logic reset;

  pc_select_unit_if #(.WIDTH(16), .JUMP_FIELD(12)) bus ();

  pc_select_unit #(
    .WIDTH     (16),
    .JUMP_FIELD(12),
    .RAS_DEPTH (4),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string name_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  obs_t  exp_obs;
  obs_t  act_obs;
  string cur_name;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_obs  = exp_q.pop_front();
      cur_name = name_q.pop_front();
      act_obs  = '{bus.pc, bus.pc_plus1, bus.redirect, bus.ras_empty, bus.ras_full,
                   bus.ras_underflow};
      vectors++;
      if (act_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL %s: got pc=%h p1=%h redir=%b empty=%b full=%b unf=%b, want pc=%h p1=%h redir=%b empty=%b full=%b unf=%b",
                 cur_name, act_obs.pc, act_obs.pc_plus1, act_obs.redirect, act_obs.ras_empty,
                 act_obs.ras_full, act_obs.ras_underflow, exp_obs.pc, exp_obs.pc_plus1,
                 exp_obs.redirect, exp_obs.ras_empty, exp_obs.ras_full, exp_obs.ras_underflow);
      end
    end
  end

  // Drive one vector before the next rising edge and queue the state expected after it.
  task automatic apply(input string nm, input logic rst, input logic stl, input logic [1:0] s,
                       input logic [15:0] bpc, input logic [11:0] imm, input logic [15:0] bt,
                       input logic [15:0] rt, input logic call, input logic ret,
                       input logic [15:0] e_pc, input logic e_redir, input logic e_empty,
                       input logic e_full, input logic e_unf);
    obs_t e;
    @(negedge clk);
    reset             = rst;
    bus.stall         = stl;
    bus.sel           = s;
    bus.base_pc       = bpc;
    bus.jump_imm      = imm;
    bus.branch_target = bt;
    bus.reg_target    = rt;
    bus.is_call       = call;
    bus.is_return     = ret;
    e = '{e_pc, e_pc + 16'h1, e_redir, e_empty, e_full, e_unf};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.sel           = 2'b00;
    bus.base_pc       = '0;
    bus.jump_imm      = '0;
    bus.branch_target = '0;
    bus.reg_target    = '0;
    bus.is_call       = 1'b0;
    bus.is_return     = 1'b0;

    //     name          rst  stl sel    base     imm     btgt     rtgt  call ret  pc  redir emp ful unf
    apply("reset",       1, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h0000, 0, 1, 0, 0);
    apply("seq1",        0, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h0001, 0, 1, 0, 0);
    apply("seq2",        0, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h0002, 0, 1, 0, 0);
    apply("seq3",        0, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h0003, 0, 1, 0, 0);
    apply("br_ffff",     0, 0, 2'b01, 16'h0, 12'h0, 16'hFFFF, 16'h0, 0, 0, 16'hFFFF, 1, 1, 0, 0);
    apply("seq_wrap",    0, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h0000, 0, 1, 0, 0);
    apply("jump",        0, 0, 2'b10, 16'h5123, 12'hABC, 16'h0, 16'h0, 0, 0, 16'h5ABC, 1, 1, 0, 0);
    apply("jump_after",  0, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h5ABD, 0, 1, 0, 0);
    apply("stall1",      0, 1, 2'b01, 16'h0, 12'h0, 16'h0040, 16'h0, 0, 0, 16'h5ABD, 0, 1, 0, 0);
    apply("stall2",      0, 1, 2'b01, 16'h0, 12'h0, 16'h0040, 16'h0, 0, 0, 16'h5ABD, 0, 1, 0, 0);
    apply("stall_rel",   0, 0, 2'b01, 16'h0, 12'h0, 16'h0040, 16'h0, 0, 0, 16'h0040, 1, 1, 0, 0);
    apply("seq_41",      0, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h0041, 0, 1, 0, 0);
`ifdef PC_SELECT_RAS_EN
    apply("push10",      0, 0, 2'b00, 16'h0010, 12'h0, 16'h0, 16'h0, 1, 0, 16'h0042, 0, 0, 0, 0);
    apply("push20",      0, 0, 2'b00, 16'h0020, 12'h0, 16'h0, 16'h0, 1, 0, 16'h0043, 0, 0, 0, 0);
    apply("push30",      0, 0, 2'b00, 16'h0030, 12'h0, 16'h0, 16'h0, 1, 0, 16'h0044, 0, 0, 0, 0);
    apply("push40",      0, 0, 2'b00, 16'h0040, 12'h0, 16'h0, 16'h0, 1, 0, 16'h0045, 0, 0, 1, 0);
    apply("push50_ovr",  0, 0, 2'b00, 16'h0050, 12'h0, 16'h0, 16'h0, 1, 0, 16'h0046, 0, 0, 1, 0);
    apply("stall_ret",   0, 1, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h0046, 0, 0, 1, 0);
    apply("ret51",       0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h0051, 1, 0, 0, 0);
    apply("ret41",       0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h0041, 1, 0, 0, 0);
    apply("ret31",       0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h0031, 1, 0, 0, 0);
    apply("ret21",       0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h0021, 1, 1, 0, 0);
    apply("ret_unf",     0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h7777, 1, 1, 0, 1);
    apply("seq_unf_clr", 0, 0, 2'b00, 16'h0, 12'h0, 16'h0, 16'h0, 0, 0, 16'h7778, 0, 1, 0, 0);
    apply("push0100",    0, 0, 2'b00, 16'h0100, 12'h0, 16'h0, 16'h0, 1, 0, 16'h7779, 0, 0, 0, 0);
    apply("call_ret",    0, 0, 2'b11, 16'h0200, 12'h0, 16'h0, 16'h7777, 1, 1, 16'h0101, 1, 0, 0, 0);
    apply("ret0201",     0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h0201, 1, 1, 0, 0);
    apply("ret_empty",   0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h7777, 0, 1, 16'h7777, 1, 1, 0, 1);
`else
    apply("call_ign",    0, 0, 2'b00, 16'h0010, 12'h0, 16'h0, 16'h0, 1, 0, 16'h0042, 0, 1, 0, 0);
    apply("ret_regtgt",  0, 0, 2'b11, 16'h0, 12'h0, 16'h0, 16'h1234, 0, 1, 16'h1234, 1, 1, 0, 0);
    apply("rst_stall",   1, 1, 2'b01, 16'h0, 12'h0, 16'h0040, 16'h0, 0, 0, 16'h0000, 0, 1, 0, 0);
    apply("br_after_rst",0, 0, 2'b01, 16'h0, 12'h0, 16'h0040, 16'h0, 0, 0, 16'h0040, 1, 1, 0, 0);
    apply("rst_over_br", 1, 0, 2'b01, 16'h0, 12'h0, 16'h0080, 16'h0, 0, 0, 16'h0000, 0, 1, 0, 0);
`endif

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
